// File: rtl/stage_mem_if.sv
// rtl/stage_mem_if.sv - data bus interface between the memory stage and its memory port
// Also carries the shared operator codes and reset level used by the stage.
`ifndef RESET_ENABLE
`define RESET_ENABLE 1'b0
`endif
`ifndef OPERATOR_LB
`define OPERATOR_LB  8'h20
`define OPERATOR_LH  8'h21
`define OPERATOR_LW  8'h23
`define OPERATOR_LBU 8'h24
`define OPERATOR_LHU 8'h25
`define OPERATOR_SB  8'h28
`define OPERATOR_SH  8'h29
`define OPERATOR_SW  8'h2B
`endif

interface stage_mem_if;
  logic        bus_request;
  logic        bus_write_enable;
  logic [31:0] bus_address;
  logic [3:0]  bus_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_acknowledge;

  modport master (
    output bus_request,
    output bus_write_enable,
    output bus_address,
    output bus_select,
    output bus_write_data,
    input  bus_read_data,
    input  bus_acknowledge
  );

  modport slave (
    input  bus_request,
    input  bus_write_enable,
    input  bus_address,
    input  bus_select,
    input  bus_write_data,
    output bus_read_data,
    output bus_acknowledge
  );
endinterface

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - MIPS memory-access stage with request/acknowledge bus and MEM/WB latch
// Optional MEM_ALIGN_CHECK_EN traps misaligned halfword/word accesses via address_error.
module stage_mem (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  operator,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_store_data,
  input  logic        register_write_enable_,
  input  logic [4:0]  register_write_address_,
  input  logic [31:0] register_write_data_,
  stage_mem_if.master bus,
  output logic        stall_request,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        address_error,
`endif
  output logic        register_write_enable,
  output logic [4:0]  register_write_address,
  output logic [31:0] register_write_data
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_t;

  state_t      state;

  logic        is_mem;
  logic        is_store;
  logic        is_signed;
  size_t       size;
  logic [1:0]  lane;
  logic [3:0]  lane_select;
  logic [31:0] lane_data;
  logic        misaligned;
  logic        mem_go;

  logic        bus_request_r;
  logic        bus_write_enable_r;
  logic [31:0] bus_address_r;
  logic [3:0]  bus_select_r;
  logic [31:0] bus_write_data_r;

  logic        cap_load;
  logic        cap_signed;
  size_t       cap_size;
  logic [1:0]  cap_lane;
  logic        cap_we;
  logic [4:0]  cap_wa;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  assign lane = memory_address[1:0];

  always_comb begin
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SIZE_WORD;
    case (operator)
      `OPERATOR_LB:  begin is_mem = 1'b1; is_signed = 1'b1; size = SIZE_BYTE; end
      `OPERATOR_LBU: begin is_mem = 1'b1; size = SIZE_BYTE; end
      `OPERATOR_LH:  begin is_mem = 1'b1; is_signed = 1'b1; size = SIZE_HALF; end
      `OPERATOR_LHU: begin is_mem = 1'b1; size = SIZE_HALF; end
      `OPERATOR_LW:  begin is_mem = 1'b1; end
      `OPERATOR_SB:  begin is_mem = 1'b1; is_store = 1'b1; size = SIZE_BYTE; end
      `OPERATOR_SH:  begin is_mem = 1'b1; is_store = 1'b1; size = SIZE_HALF; end
      `OPERATOR_SW:  begin is_mem = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
  end

  // Big-endian lanes: lane 0 is bits[31:24]; unused low address bits are simply ignored.
  always_comb begin
    lane_select = 4'b1111;
    lane_data   = memory_store_data;
    case (size)
      SIZE_BYTE: begin
        lane_select = 4'b1000 >> lane;
        lane_data   = {4{memory_store_data[7:0]}};
      end
      SIZE_HALF: begin
        lane_select = lane[1] ? 4'b0011 : 4'b1100;
        lane_data   = {2{memory_store_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem && (((size == SIZE_HALF) && lane[0]) ||
                                 ((size == SIZE_WORD) && (lane != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign mem_go        = is_mem && !misaligned;
  assign stall_request = ((state == IDLE) && mem_go) ||
                         ((state == ACCESS) && !bus.bus_acknowledge);

  always_comb begin
    load_byte = bus.bus_read_data[31:24];
    case (cap_lane)
      2'd1:    load_byte = bus.bus_read_data[23:16];
      2'd2:    load_byte = bus.bus_read_data[15:8];
      2'd3:    load_byte = bus.bus_read_data[7:0];
      default: ;
    endcase
    load_half  = cap_lane[1] ? bus.bus_read_data[15:0] : bus.bus_read_data[31:16];
    load_value = bus.bus_read_data;
    case (cap_size)
      SIZE_BYTE: load_value = cap_signed ? {{24{load_byte[7]}}, load_byte} : {24'h0, load_byte};
      SIZE_HALF: load_value = cap_signed ? {{16{load_half[15]}}, load_half} : {16'h0, load_half};
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset == `RESET_ENABLE) begin
      state                  <= IDLE;
      bus_request_r          <= 1'b0;
      bus_write_enable_r     <= 1'b0;
      bus_address_r          <= 32'h0;
      bus_select_r           <= 4'h0;
      bus_write_data_r       <= 32'h0;
      cap_load               <= 1'b0;
      cap_signed             <= 1'b0;
      cap_size               <= SIZE_BYTE;
      cap_lane               <= 2'b00;
      cap_we                 <= 1'b0;
      cap_wa                 <= 5'h0;
      register_write_enable  <= 1'b0;
      register_write_address <= 5'h0;
      register_write_data    <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
      address_error          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_go) begin
            state                 <= ACCESS;
            bus_request_r         <= 1'b1;
            bus_write_enable_r    <= is_store;
            bus_address_r         <= {memory_address[31:2], 2'b00};
            bus_select_r          <= lane_select;
            bus_write_data_r      <= is_store ? lane_data : 32'h0;
            cap_load              <= !is_store;
            cap_signed            <= is_signed;
            cap_size              <= size;
            cap_lane              <= lane;
            cap_we                <= register_write_enable_;
            cap_wa                <= register_write_address_;
            register_write_enable <= 1'b0;
          end else if (is_mem) begin
            // Trapped misaligned op: no transfer, write-back suppressed.
            register_write_enable <= 1'b0;
          end else begin
            register_write_enable  <= register_write_enable_;
            register_write_address <= register_write_address_;
            register_write_data    <= register_write_data_;
          end
`ifdef MEM_ALIGN_CHECK_EN
          address_error <= misaligned;
`endif
        end
        ACCESS: begin
          if (bus.bus_acknowledge) begin
            state         <= IDLE;
            bus_request_r <= 1'b0;
            if (cap_load) begin
              register_write_enable  <= cap_we;
              register_write_address <= cap_wa;
              register_write_data    <= load_value;
            end else begin
              register_write_enable <= 1'b0;
            end
          end else begin
            register_write_enable <= 1'b0;
          end
`ifdef MEM_ALIGN_CHECK_EN
          address_error <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_request      = bus_request_r;
  assign bus.bus_write_enable = bus_write_enable_r;
  assign bus.bus_address      = bus_address_r;
  assign bus.bus_select       = bus_select_r;
  assign bus.bus_write_data   = bus_write_data_r;

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - randomized self-checking bench for stage_mem against a transaction-level model
// Honours MEM_ALIGN_CHECK_EN when the design is built with it.
`ifndef RESET_ENABLE
`define RESET_ENABLE 1'b0
`endif
`ifndef OPERATOR_LB
`define OPERATOR_LB  8'h20
`define OPERATOR_LH  8'h21
`define OPERATOR_LW  8'h23
`define OPERATOR_LBU 8'h24
`define OPERATOR_LHU 8'h25
`define OPERATOR_SB  8'h28
`define OPERATOR_SH  8'h29
`define OPERATOR_SW  8'h2B
`endif

module tb_stage_mem;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  operator;
  logic [31:0] memory_address;
  logic [31:0] memory_store_data;
  logic        register_write_enable_;
  logic [4:0]  register_write_address_;
  logic [31:0] register_write_data_;
  logic        stall_request;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        address_error;
`endif

  stage_mem_if bus_if ();

  stage_mem dut (
    .clock                   (clock),
    .reset                   (reset),
    .operator                (operator),
    .memory_address          (memory_address),
    .memory_store_data       (memory_store_data),
    .register_write_enable_  (register_write_enable_),
    .register_write_address_ (register_write_address_),
    .register_write_data_    (register_write_data_),
    .bus                     (bus_if),
    .stall_request           (stall_request),
`ifdef MEM_ALIGN_CHECK_EN
    .address_error           (address_error),
`endif
    .register_write_enable   (register_write_enable),
    .register_write_address  (register_write_address),
    .register_write_data     (register_write_data)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0]  m_wa = 5'h0;
  logic [31:0] m_wd = 32'h0;
  logic [7:0]  mem_ops [8] = '{`OPERATOR_LB, `OPERATOR_LBU, `OPERATOR_LH, `OPERATOR_LHU,
                               `OPERATOR_LW, `OPERATOR_SB, `OPERATOR_SH, `OPERATOR_SW};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mem_op(input logic [7:0] op);
    foreach (mem_ops[i]) if (mem_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_store_op(input logic [7:0] op);
    return op == `OPERATOR_SB || op == `OPERATOR_SH || op == `OPERATOR_SW;
  endfunction

  function automatic bit is_signed_op(input logic [7:0] op);
    return op == `OPERATOR_LB || op == `OPERATOR_LH;
  endfunction

  function automatic int size_of(input logic [7:0] op);
    if (op == `OPERATOR_LB || op == `OPERATOR_LBU || op == `OPERATOR_SB) return 1;
    if (op == `OPERATOR_LH || op == `OPERATOR_LHU || op == `OPERATOR_SH) return 2;
    return 4;
  endfunction

  // Byte offset within the word actually used, after dropping ignored low bits.
  function automatic int lane_off(input logic [7:0] op, input logic [1:0] a);
    int b = size_of(op);
    if (b == 1) return int'(a);
    if (b == 2) return int'(a) & 2;
    return 0;
  endfunction

  function automatic bit misaligned_m(input logic [7:0] op, input logic [1:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    int b = size_of(op);
    return is_mem_op(op) && ((b == 2 && a[0]) || (b == 4 && a != 2'b00));
`else
    return (op == 8'hFF) && (a == 2'b11) && 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_select(input logic [7:0] op, input logic [1:0] a);
    int b = size_of(op);
    int s;
    s = (((1 << b) - 1) << (4 - b)) >> lane_off(op, a);
    return s[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] sd);
    int b = size_of(op);
    if (b == 1) return {24'h0, sd[7:0]} * 32'h01010101;
    if (b == 2) return {16'h0, sd[15:0]} * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    int b = size_of(op);
    int off = lane_off(op, a);
    logic [63:0] mask, v;
    mask = (64'd1 << (8 * b)) - 64'd1;
    v = ({32'h0, rd} >> (8 * (4 - off - b))) & mask;
    if (is_signed_op(op) && v[8 * b - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic check_aerr(input string tag, input bit exp);
`ifdef MEM_ALIGN_CHECK_EN
    check(tag, address_error, exp);
`else
    if (exp) check(tag, 1'b0, 1'b1);
`endif
  endtask

  // Present one op in IDLE at posedge+1 and follow it to its write-back edge.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits);
    logic [31:0] ld;
    operator = op; memory_address = addr; memory_store_data = sd;
    register_write_enable_ = we; register_write_address_ = wa; register_write_data_ = wd;
    bus_if.bus_read_data = $urandom; bus_if.bus_acknowledge = 1'b0;
    #1;
    if (!is_mem_op(op)) begin
      check("stall_nonmem", stall_request, 1'b0);
      @(posedge clock); #1;
      check("nm_we", register_write_enable, we);
      check("nm_wa", register_write_address, wa);
      check("nm_wd", register_write_data, wd);
      check("nm_req", bus_if.bus_request, 1'b0);
      check_aerr("nm_aerr", 1'b0);
      m_wa = wa; m_wd = wd;
    end else if (misaligned_m(op, addr[1:0])) begin
      check("stall_mis", stall_request, 1'b0);
      @(posedge clock); #1;
      check_aerr("mis_aerr", 1'b1);
      check("mis_we", register_write_enable, 1'b0);
      check("mis_req", bus_if.bus_request, 1'b0);
      check("mis_wd", register_write_data, m_wd);
    end else begin
      check("stall_idle", stall_request, 1'b1);
      @(posedge clock); #1;
      check("req", bus_if.bus_request, 1'b1);
      check("addr", bus_if.bus_address, {addr[31:2], 2'b00});
      check("sel", bus_if.bus_select, exp_select(op, addr[1:0]));
      check("bwe", bus_if.bus_write_enable, is_store_op(op));
      if (is_store_op(op)) check("bwdata", bus_if.bus_write_data, exp_wdata(op, sd));
      check("bubble_we", register_write_enable, 1'b0);
      check("bubble_wa", register_write_address, m_wa);
      check("bubble_wd", register_write_data, m_wd);
      check_aerr("acc_aerr", 1'b0);
      operator = 8'($urandom); memory_address = $urandom; memory_store_data = $urandom;
      register_write_enable_ = 1'($urandom); register_write_address_ = 5'($urandom);
      register_write_data_ = $urandom;
      for (int w = 0; w < waits; w++) begin
        bus_if.bus_read_data = $urandom;
        #1;
        check("stall_wait", stall_request, 1'b1);
        @(posedge clock); #1;
        check("wait_we", register_write_enable, 1'b0);
        check("wait_req", bus_if.bus_request, 1'b1);
        check("wait_addr", bus_if.bus_address, {addr[31:2], 2'b00});
      end
      bus_if.bus_acknowledge = 1'b1; bus_if.bus_read_data = rd;
      #1;
      check("stall_ack", stall_request, 1'b0);
      @(posedge clock); #1;
      bus_if.bus_acknowledge = 1'b0;
      check("done_req", bus_if.bus_request, 1'b0);
      if (is_store_op(op)) begin
        check("st_we", register_write_enable, 1'b0);
        check("st_wa", register_write_address, m_wa);
        check("st_wd", register_write_data, m_wd);
      end else begin
        ld = exp_load(op, addr[1:0], rd);
        check("ld_we", register_write_enable, we);
        check("ld_wa", register_write_address, wa);
        check("ld_wd", register_write_data, ld);
        m_wa = wa; m_wd = ld;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] op;
    reset = `RESET_ENABLE;
    operator = 8'h00; memory_address = 32'h0; memory_store_data = 32'h0;
    register_write_enable_ = 1'b0; register_write_address_ = 5'h0; register_write_data_ = 32'h0;
    bus_if.bus_read_data = 32'h0; bus_if.bus_acknowledge = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", bus_if.bus_request, 1'b0);
    check("rst_sel", bus_if.bus_select, 4'h0);
    check("rst_addr", bus_if.bus_address, 32'h0);
    check("rst_we", register_write_enable, 1'b0);
    check("rst_wd", register_write_data, 32'h0);
    check("rst_stall", stall_request, 1'b0);
    check_aerr("rst_aerr", 1'b0);
    reset = ~`RESET_ENABLE;
    @(posedge clock); #1;

    do_op(8'h00, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000F0F0, 32'h0, 0);
    do_op(`OPERATOR_LB, 32'h103, 32'h0, 1'b1, 5'd9, 32'h0, 32'h112233F4, 2);
    check("lb_result", register_write_data, 32'hFFFFFFF4);
    do_op(`OPERATOR_LHU, 32'h202, 32'h0, 1'b1, 5'd10, 32'h0, 32'hABCD8001, 0);
    check("lhu_result", register_write_data, 32'h00008001);
    do_op(`OPERATOR_SB, 32'h201, 32'h000000A5, 1'b1, 5'd11, 32'h0, 32'h0, 1);
    do_op(`OPERATOR_LW, 32'h102, 32'h0, 1'b1, 5'd12, 32'h0, 32'hCAFEF00D, 1);
    do_op(8'h00, 32'h0, 32'h0, 1'b1, 5'd1, 32'h11111111, 32'h0, 0);

    // Acknowledge while idle must not start or finish anything.
    bus_if.bus_acknowledge = 1'b1;
    @(posedge clock); #1;
    check("idle_ack_req", bus_if.bus_request, 1'b0);
    check("idle_ack_wd", register_write_data, 32'h11111111);
    bus_if.bus_acknowledge = 1'b0;

    // Reset while a word load is outstanding.
    operator = `OPERATOR_LW; memory_address = 32'h300;
    register_write_enable_ = 1'b1; register_write_address_ = 5'd7;
    @(posedge clock); #1;
    check("rsta_req", bus_if.bus_request, 1'b1);
    reset = `RESET_ENABLE;
    operator = 8'h00; register_write_enable_ = 1'b0; register_write_address_ = 5'h0;
    register_write_data_ = 32'h0;
    @(posedge clock); #1;
    check("rsta_req0", bus_if.bus_request, 1'b0);
    check("rsta_sel0", bus_if.bus_select, 4'h0);
    check("rsta_addr0", bus_if.bus_address, 32'h0);
    check("rsta_we0", register_write_enable, 1'b0);
    check("rsta_wd0", register_write_data, 32'h0);
    reset = ~`RESET_ENABLE;
    bus_if.bus_acknowledge = 1'b1; bus_if.bus_read_data = 32'h12345678;
    #1;
    check("rsta_stall", stall_request, 1'b0);
    @(posedge clock); #1;
    bus_if.bus_acknowledge = 1'b0;
    check("late_ack_we", register_write_enable, 1'b0);
    check("late_ack_wd", register_write_data, 32'h0);
    check("late_ack_req", bus_if.bus_request, 1'b0);
    m_wa = 5'h0; m_wd = 32'h0;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 7) op = mem_ops[$urandom_range(0, 7)];
      else begin
        op = 8'($urandom);
        while (is_mem_op(op)) op = 8'($urandom);
      end
      do_op(op, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom,
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
